div_radix2_unit: RTL and testbench

- Iterative unsigned radix-2 restoring divider. It is the responder side of the divide handshake used by the CPU multiply/divide unit.
- The initiator presents operand magnitudes and pulses start. The divider returns quotient and remainder with a level done flag after a fixed WIDTH-cycle latency.
- Sign handling, HI/LO writeback and operand absolute values belong to the initiator. This block is purely unsigned.

---
 rtl/div_radix2_unit.sv | 87 ++++++++
 tb/tb_div_radix2_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/div_radix2_unit.sv
// Iterative unsigned radix-2 restoring divider that produces one quotient bit per clock.
// The state is {busy, done}: IDLE=00, RUN=10, DONE=01. A start edge reloads from any state.
module div_radix2_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             done,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] qreg_q, qreg_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // Every register, including the RUN/DONE state bits, updates here.
  always_ff @(posedge clk) begin
    if (rst) begin
      qreg_q <= '0;
      rem_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      qreg_q <= qreg_d;
      rem_q  <= rem_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // Shift the next dividend bit into the partial remainder and try to subtract.
  always_comb begin
    shifted = {rem_q, qreg_q[WIDTH-1]};
    trial   = shifted - {1'b0, div_q};
  end

  always_comb begin
    qreg_d = qreg_q;
    rem_d  = rem_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = done_q;
    if (start) begin
      qreg_d = a;
      rem_d  = '0;
      div_d  = b;
      cnt_d  = '0;
      busy_d = 1'b1;
      done_d = 1'b0;
    end else if (busy_q) begin
      // A borrow out of the top bit means the divisor did not fit, so restore.
      rem_d  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      qreg_d = {qreg_q[WIDTH-2:0], ~trial[WIDTH]};
      cnt_d  = cnt_q + 1'b1;
      if (cnt_q == LAST_ITER) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_comb begin
    q    = qreg_q;
    r    = rem_q;
    done = done_q;
    busy = busy_q;
  end

endmodule

// File: tb/tb_div_radix2_unit.sv
// Self-checking bench for div_radix2_unit: directed vectors, corner sequences and random operands
// checked against plain integer division.
module tb_div_radix2_unit;

  localparam int W       = 32;
  localparam int LAT     = 32;
  localparam int BUDGET  = 40;
  localparam int NRANDOM = 1000;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         done;
  logic         busy;

  int tests;
  int fails;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  vec_t vecs[8];

  div_radix2_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .q    (q),
    .r    (r),
    .done (done),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] av, input logic [W-1:0] bv);
    start = 1'b1;
    a     = av;
    b     = bv;
    step();
    start = 1'b0;
  endtask

  // Counts edges after the load edge until done; flags any cycle where busy dropped early.
  task automatic wait_done(output int lat, output logic busy_ok);
    lat     = -1;
    busy_ok = 1'b1;
    for (int n = 1; n <= BUDGET; n++) begin
      if (busy !== 1'b1 || done !== 1'b0) busy_ok = 1'b0;
      step();
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_q"}, 64'(q), 64'd0);
    check({tag, "_r"}, 64'(r), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int          lat;
    logic        busy_ok;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic [W-1:0] hq;
    logic [W-1:0] hr;

    tests = 0;
    fails = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;

    vecs[0] = '{a: 32'd100,        b: 32'd7,          q: 32'd14,         r: 32'd2};
    vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'd1,          q: 32'hFFFF_FFFF,  r: 32'd0};
    vecs[2] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  q: 32'd1,          r: 32'd0};
    vecs[3] = '{a: 32'd5,          b: 32'd9,          q: 32'd0,          r: 32'd5};
    vecs[4] = '{a: 32'h1234_5678,  b: 32'd0,          q: 32'hFFFF_FFFF,  r: 32'h1234_5678};
    vecs[5] = '{a: 32'd0,          b: 32'd5,          q: 32'd0,          r: 32'd0};
    vecs[6] = '{a: 32'd81,         b: 32'd9,          q: 32'd9,          r: 32'd0};
    vecs[7] = '{a: 32'h8000_0000,  b: 32'd3,          q: 32'h2AAA_AAAA,  r: 32'd2};

    step();
    step();
    check_reset_state("reset");
    rst = 1'b0;
    step();
    check_reset_state("idle");

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      load(vecs[i].a, vecs[i].b);
      wait_done(lat, busy_ok);
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'(LAT));
      check($sformatf("vec%0d_busy", i), 64'(busy_ok), 64'd1);
      check($sformatf("vec%0d_q", i), 64'(q), 64'(vecs[i].q));
      check($sformatf("vec%0d_r", i), 64'(r), 64'(vecs[i].r));
      $display("[TB] vec%0d a=%0h b=%0h -> q=%0h r=%0h lat=%0d", i, vecs[i].a, vecs[i].b, q, r, lat);
    end

    // Results hold through idle cycles while the operand inputs wander.
    load(32'd100, 32'd7);
    wait_done(lat, busy_ok);
    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      b = $urandom;
      step();
      check("hold_q", 64'(q), 64'd14);
      check("hold_r", 64'(r), 64'd2);
      check("hold_done", 64'(done), 64'd1);
      check("hold_busy", 64'(busy), 64'd0);
    end
    $display("[TB] hold after 100/7 q=%0d r=%0d done=%0b", q, r, done);

    // Restart mid-operation: only the second division may complete, 32 edges after its load.
    load(32'd1000, 32'd3);
    for (int i = 0; i < 9; i++) step();
    load(32'd81, 32'd9);
    wait_done(lat, busy_ok);
    check("restart_lat", 64'(lat), 64'(LAT));
    check("restart_busy", 64'(busy_ok), 64'd1);
    check("restart_q", 64'(q), 64'd9);
    check("restart_r", 64'(r), 64'd0);
    $display("[TB] restart 1000/3 -> 81/9 q=%0d r=%0d lat=%0d", q, r, lat);

    // Reset mid-operation aborts; no done afterwards.
    load(32'd1000, 32'd3);
    for (int i = 0; i < 15; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_state("midrst");
    for (int i = 0; i < LAT + 4; i++) step();
    check("midrst_nodone", 64'(done), 64'd0);
    $display("[TB] reset at iteration 15 busy=%0b done=%0b", busy, done);

    // Reset wins over start on the same edge.
    rst   = 1'b1;
    start = 1'b1;
    a     = 32'd50;
    b     = 32'd5;
    step();
    rst   = 1'b0;
    start = 1'b0;
    check_reset_state("rst_start");
    step();
    check("rst_start_idle", 64'({busy, done}), 64'd0);
    $display("[TB] rst+start same edge busy=%0b done=%0b", busy, done);

    // Start held over several edges: the last sampled operands win.
    start = 1'b1;
    a = 32'd1000; b = 32'd3;  step();
    a = 32'd999;  b = 32'd10; step();
    a = 32'd77;   b = 32'd8;  step();
    start = 1'b0;
    wait_done(lat, busy_ok);
    check("held_lat", 64'(lat), 64'(LAT));
    check("held_q", 64'(q), 64'd9);
    check("held_r", 64'(r), 64'd5);
    $display("[TB] held start last 77/8 q=%0d r=%0d lat=%0d", q, r, lat);

    // Random back-to-back divisions, each started on the cycle done appears.
    for (int i = 0; i < NRANDOM; i++) begin
      ra = (i % 4 == 0) ? W'($urandom_range(0, 1000)) : W'($urandom);
      rb = (i % 3 == 0) ? W'($urandom_range(1, 255)) : W'($urandom);
      if (rb == 0) rb = 1;
      eq = ra / rb;
      er = ra % rb;
      load(ra, rb);
      wait_done(lat, busy_ok);
      hq = q;
      hr = r;
      check("rand_lat", 64'(lat), 64'(LAT));
      check("rand_q", 64'(hq), 64'(eq));
      check("rand_r", 64'(hr), 64'(er));
      check("rand_inv", 64'(hq) * 64'(rb) + 64'(hr), 64'(ra));
      check("rand_rlt", 64'(hr < rb), 64'd1);
      $display("[TB] rand%0d a=%0h b=%0h -> q=%0h r=%0h lat=%0d", i, ra, rb, hq, hr, lat);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
